axis_arb_mux_n: RTL and testbench
=================================

// Module: axis_arb_mux_n
// PURPOSE
//  AXI4-Stream N-to-1 arbitrated multiplexer with packet-granular arbitration.
//  Generalises the 2-port mux to PORTS inputs and flattened vector ports, and
//  tags every output beat with its source port (output_axis_tid).
//  A registered skid-buffer output stage cuts the output_axis_tready -> input_tready path.
//  Sits between per-channel DSP/record streams and the shared DMA/record output.
// PARAMETERS
//  PORTS         4              number of input ports, 1..32
//  DATA_WIDTH    32             tdata width per port
//  ARB_TYPE      "ROUND_ROBIN"  "PRIORITY" or "ROUND_ROBIN"
//  LSB_PRIORITY  "HIGH"         "HIGH": port 0 wins ties / is fixed-highest; "LOW": port PORTS-1
//  ID_WIDTH      (localparam)   max(1, clog2(PORTS))
// PORTS
//  clk                  in   1                 single clock, all logic rising-edge
//  rst_n                in   1                 synchronous reset, active low
//  input_axis_tdata     in   PORTS*DATA_WIDTH  port i at [i*DATA_WIDTH +: DATA_WIDTH]
//  input_axis_tvalid    in   PORTS             per-port valid
//  input_axis_tready    out  PORTS             per-port ready; only granted bit may be 1
//  input_axis_tlast     in   PORTS             per-port end of packet
//  input_axis_tuser     in   PORTS             per-port user flag
//  output_axis_tdata    out  DATA_WIDTH        muxed data
//  output_axis_tvalid   out  1                 output valid
//  output_axis_tready   in   1                 downstream ready
//  output_axis_tlast    out  1                 end of packet
//  output_axis_tuser    out  1                 user flag
//  output_axis_tid      out  ID_WIDTH          source port index of current beat
// BEHAVIOUR
//  Reset (rst_n=0 at edge): output_axis_tvalid/tdata/tlast/tuser/tid=0, input_axis_tready=0,
//   grant_valid=0, skid buffer emptied, RR pointer set so the LSB_PRIORITY-favoured port is highest.
//   A packet in flight at reset is abandoned; no tlast is emitted for it.
//  Arbiter state: IDLE (grant_valid=0) / LOCKED (grant_valid=1, grant=g).
//   request[i] = tvalid[i] & ~(tvalid[i] & tready[i] & tlast[i]).
//   IDLE -> LOCKED at the edge where request!=0; winner per ARB_TYPE/pointer, grant registered.
//   LOCKED -> stays on g until beat with tlast from port g is accepted; at that edge re-arbitrate
//    over request: any request -> LOCKED on new winner (zero-bubble back-to-back), else IDLE.
//   The same port may win again only if it is the sole requester (RR) or highest priority (PRIORITY).
//   ROUND_ROBIN: on packet completion from g, g becomes lowest priority.
//   PRIORITY: fixed order per LSB_PRIORITY; no pointer update.
//   Grant never changes mid-packet; granted port dropping tvalid mid-packet holds grant (no timeout).
//  Input handshake: input_axis_tready[i] = grant_valid & (grant==i) & ~skid_full (from registers only).
//   Beat accepted when tvalid[g]&tready[g]; tdata/tlast/tuser and tid=g are captured together.
//  Output stage: 2-entry skid buffer, registered outputs; throughput 1 beat/cycle while
//   output_axis_tready=1. Once tvalid=1, tdata/tlast/tuser/tid stay stable until tready.
//   skid_full: both entries occupied -> all input_axis_tready=0.
//  Latency: tvalid[i] rising in IDLE at cycle 0 -> grant at edge 1 -> tready[i]=1 in cycle 1
//   -> first beat on output_axis_tvalid in cycle 2. Steady state: 1 cycle input->output.
//  PORTS=1: arbiter degenerates to pass-through with the same latency; tid always 0.
//  No combinational path from any input to any output.
// TESTING
//  1 Single port: port 2 sends 4-beat pkt D=0x10..0x13, tready=1 -> out 0x10..0x13, tid=2,
//    tlast on 4th beat, first out beat in cycle 2.
//  2 RR contention: ports 0,1,3 each hold 2-beat pkts continuously -> packet order 0,1,3,0,1,3;
//    no idle cycle between packets; beats never interleave.
//  3 PRIORITY, LSB_PRIORITY="HIGH": ports 0 and 3 always valid -> only port 0 served;
//    port 3 served once port 0 tvalid drops after tlast.
//  4 Backpressure: output_axis_tready toggles 1,0,0,1 during 8-beat pkt -> all 8 beats
//    delivered in order, none duplicated or lost, output held stable while tready=0.
//  5 Mid-packet stall: granted port 1 drops tvalid 3 cycles after beat 2 while port 0 is valid
//    -> port 0 receives no tready until port 1's tlast is accepted.
//  6 Reset mid-packet: rst_n=0 for 1 cycle after beat 3 of 6 -> next cycle all outputs 0;
//    new pkt after reset is delivered with correct tid and 2-cycle latency.

Source files
------------

// File: rtl/axis_arb_mux_n.sv
// AXI4-Stream N-to-1 arbitrated mux: packet-granular arbitration, source tagging
// on output_axis_tid, and a 2-entry registered skid buffer on the output side.
module axis_arb_mux_n #(
  parameter int    PORTS        = 4,
  parameter int    DATA_WIDTH   = 32,
  parameter string ARB_TYPE     = "ROUND_ROBIN",
  parameter string LSB_PRIORITY = "HIGH",
  localparam int   ID_WIDTH     = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [PORTS*DATA_WIDTH-1:0] input_axis_tdata,
  input  logic [PORTS-1:0]            input_axis_tvalid,
  output logic [PORTS-1:0]            input_axis_tready,
  input  logic [PORTS-1:0]            input_axis_tlast,
  input  logic [PORTS-1:0]            input_axis_tuser,
  output logic [DATA_WIDTH-1:0]       output_axis_tdata,
  output logic                        output_axis_tvalid,
  input  logic                        output_axis_tready,
  output logic                        output_axis_tlast,
  output logic                        output_axis_tuser,
  output logic [ID_WIDTH-1:0]         output_axis_tid
);

  localparam int unsigned NP     = PORTS;
  localparam bit          RR     = (ARB_TYPE == "ROUND_ROBIN");
  localparam bit          LSB_HI = (LSB_PRIORITY == "HIGH");
  localparam logic [ID_WIDTH-1:0] PTR_INIT = LSB_HI ? '0 : ID_WIDTH'(PORTS - 1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                  state, state_n;
  logic [ID_WIDTH-1:0]     grant, grant_n, ptr, ptr_n;
  logic [ID_WIDTH:0]       pick_r;
  logic [PORTS-1:0]        request;
  logic [DATA_WIDTH-1:0]   sel_data;
  logic                    sel_valid, sel_last, sel_user;
  logic                    accept, done;

  logic                    skid_valid;
  logic [DATA_WIDTH-1:0]   skid_data;
  logic                    skid_last, skid_user;
  logic [ID_WIDTH-1:0]     skid_id;

  // Search order starts at 'start' and walks toward the less-favoured end, wrapping.
  function automatic logic [ID_WIDTH:0] pick(input logic [PORTS-1:0] req,
                                             input logic [ID_WIDTH-1:0] start);
    logic [ID_WIDTH:0] r;
    int unsigned idx;
    r = '0;
    for (int unsigned k = 0; k < NP; k++) begin
      idx = LSB_HI ? (32'(start) + k) % NP : (32'(start) + NP - k) % NP;
      if (req[idx] && !r[ID_WIDTH]) r = {1'b1, idx[ID_WIDTH-1:0]};
    end
    return r;
  endfunction

  function automatic logic [ID_WIDTH-1:0] adv(input logic [ID_WIDTH-1:0] g);
    int unsigned n;
    n = LSB_HI ? (32'(g) + 1) % NP : (32'(g) + NP - 1) % NP;
    return n[ID_WIDTH-1:0];
  endfunction

  always_comb begin
    input_axis_tready = '0;
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_user  = 1'b0;
    for (int unsigned i = 0; i < NP; i++) begin
      if (32'(grant) == i) begin
        input_axis_tready[i] = (state == LOCKED) && !skid_valid;
        sel_data  = input_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_valid = input_axis_tvalid[i];
        sel_last  = input_axis_tlast[i];
        sel_user  = input_axis_tuser[i];
      end
    end
  end

  assign request = input_axis_tvalid & ~(input_axis_tvalid & input_axis_tready & input_axis_tlast);
  assign accept  = (state == LOCKED) && sel_valid && !skid_valid;
  assign done    = accept && sel_last;

  always_comb begin
    state_n = state;
    grant_n = grant;
    ptr_n   = ptr;
    pick_r  = '0;
    case (state)
      IDLE: begin
        pick_r = pick(request, ptr);
        if (pick_r[ID_WIDTH]) begin
          state_n = LOCKED;
          grant_n = pick_r[ID_WIDTH-1:0];
        end
      end
      LOCKED: begin
        if (done) begin
          if (RR) ptr_n = adv(grant);
          pick_r = pick(request, RR ? adv(grant) : ptr);
          if (pick_r[ID_WIDTH]) grant_n = pick_r[ID_WIDTH-1:0];
          else                  state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      grant <= '0;
      ptr   <= PTR_INIT;
    end else begin
      state <= state_n;
      grant <= grant_n;
      ptr   <= ptr_n;
    end
  end

  // Skid entry only fills while the output register is stalled; it drains first.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      output_axis_tvalid <= 1'b0;
      output_axis_tdata  <= '0;
      output_axis_tlast  <= 1'b0;
      output_axis_tuser  <= 1'b0;
      output_axis_tid    <= '0;
      skid_valid         <= 1'b0;
      skid_data          <= '0;
      skid_last          <= 1'b0;
      skid_user          <= 1'b0;
      skid_id            <= '0;
    end else if (!output_axis_tvalid || output_axis_tready) begin
      if (skid_valid) begin
        output_axis_tvalid <= 1'b1;
        output_axis_tdata  <= skid_data;
        output_axis_tlast  <= skid_last;
        output_axis_tuser  <= skid_user;
        output_axis_tid    <= skid_id;
        skid_valid         <= 1'b0;
      end else if (accept) begin
        output_axis_tvalid <= 1'b1;
        output_axis_tdata  <= sel_data;
        output_axis_tlast  <= sel_last;
        output_axis_tuser  <= sel_user;
        output_axis_tid    <= grant;
      end else begin
        output_axis_tvalid <= 1'b0;
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_data  <= sel_data;
      skid_last  <= sel_last;
      skid_user  <= sel_user;
      skid_id    <= grant;
    end
  end

endmodule

// File: tb/tb_axis_arb_mux_n.sv
// Bench for axis_arb_mux_n: a round-robin and a fixed-priority instance share
// one set of stimulus; per-port packet sources plus an output beat monitor.
module tb_axis_arb_mux_n;

  localparam int P  = 4;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [P*DW-1:0]   in_data;
  logic [P-1:0]      in_valid, in_last, in_user;
  logic [P-1:0]      rdy_rr, rdy_pri;
  logic [DW-1:0]     od_rr, od_pri;
  logic              ov_rr, ov_pri, ol_rr, ol_pri, ou_rr, ou_pri;
  logic [1:0]        oid_rr, oid_pri;
  logic              out_ready;
  logic              use_pri;

  axis_arb_mux_n #(.PORTS(P), .DATA_WIDTH(DW), .ARB_TYPE("ROUND_ROBIN"), .LSB_PRIORITY("HIGH")) u_rr (
    .clk(clk), .rst_n(rst_n),
    .input_axis_tdata(in_data), .input_axis_tvalid(in_valid), .input_axis_tready(rdy_rr),
    .input_axis_tlast(in_last), .input_axis_tuser(in_user),
    .output_axis_tdata(od_rr), .output_axis_tvalid(ov_rr), .output_axis_tready(out_ready),
    .output_axis_tlast(ol_rr), .output_axis_tuser(ou_rr), .output_axis_tid(oid_rr));

  axis_arb_mux_n #(.PORTS(P), .DATA_WIDTH(DW), .ARB_TYPE("PRIORITY"), .LSB_PRIORITY("HIGH")) u_pri (
    .clk(clk), .rst_n(rst_n),
    .input_axis_tdata(in_data), .input_axis_tvalid(in_valid), .input_axis_tready(rdy_pri),
    .input_axis_tlast(in_last), .input_axis_tuser(in_user),
    .output_axis_tdata(od_pri), .output_axis_tvalid(ov_pri), .output_axis_tready(out_ready),
    .output_axis_tlast(ol_pri), .output_axis_tuser(ou_pri), .output_axis_tid(oid_pri));

  logic [P-1:0]  sel_rdy;
  logic [DW-1:0] sel_od;
  logic          sel_ov, sel_ol, sel_ou;
  logic [1:0]    sel_oid;
  assign sel_rdy = use_pri ? rdy_pri : rdy_rr;
  assign sel_od  = use_pri ? od_pri  : od_rr;
  assign sel_ov  = use_pri ? ov_pri  : ov_rr;
  assign sel_ol  = use_pri ? ol_pri  : ol_rr;
  assign sel_ou  = use_pri ? ou_pri  : ou_rr;
  assign sel_oid = use_pri ? oid_pri : oid_rr;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int unsigned m_beat[P], m_pkt[P], m_len[P], m_npkt[P], m_stall_at[P], m_stall_left[P];
  bit          m_en[P];
  bit          bp_en;
  logic [3:0]  bp_pat = 4'b1001;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic        user;
    logic [1:0]  tid;
    int          cyc;
  } beat_t;
  beat_t cap[$];

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        l;
    logic        ev;
    logic [31:0] ed;
    logic        el;
    logic [1:0]  eid;
    logic [3:0]  erdy;
  } vec_t;
  vec_t tv[7];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] bdata(input int unsigned p, input int unsigned pk, input int unsigned b);
    return 32'hA000_0000 | (p << 8) | (pk << 4) | b;
  endfunction

  function automatic logic buser(input int unsigned p, input int unsigned b);
    return logic'(b[0] ^ p[0]);
  endfunction

  function automatic bit src_active(input int unsigned p);
    return m_en[p] && (m_pkt[p] < m_npkt[p]);
  endfunction

  function automatic bit src_stalled(input int unsigned p);
    return (m_beat[p] == m_stall_at[p]) && (m_stall_left[p] > 0);
  endfunction

  task automatic drive();
    for (int unsigned p = 0; p < P; p++) begin
      in_valid[p]         = src_active(p) && !src_stalled(p);
      in_data[p*DW +: DW] = bdata(p, m_pkt[p], m_beat[p]);
      in_last[p]          = (m_beat[p] == m_len[p] - 1);
      in_user[p]          = buser(p, m_beat[p]);
    end
    out_ready = bp_en ? bp_pat[cyc % 4] : 1'b1;
  endtask

  task automatic tick();
    logic [P-1:0] fire;
    beat_t b;
    fire = in_valid & sel_rdy;
    if (sel_ov && out_ready) begin
      b.data = sel_od; b.last = sel_ol; b.user = sel_ou; b.tid = sel_oid; b.cyc = cyc;
      cap.push_back(b);
    end
    for (int unsigned p = 0; p < P; p++) begin
      if (src_active(p) && src_stalled(p)) m_stall_left[p]--;
      if (fire[p]) begin
        if (m_beat[p] == m_len[p] - 1) begin
          m_beat[p] = 0;
          m_pkt[p]++;
        end else begin
          m_beat[p]++;
        end
      end
    end
    @(posedge clk); #1;
    cyc++;
    drive();
  endtask

  task automatic clear_model();
    for (int unsigned p = 0; p < P; p++) begin
      m_beat[p] = 0; m_pkt[p] = 0; m_len[p] = 0; m_npkt[p] = 0;
      m_stall_at[p] = 32'hFFFF_FFFF; m_stall_left[p] = 0; m_en[p] = 1'b0;
    end
    bp_en = 1'b0;
    cap.delete();
  endtask

  task automatic src(input int unsigned p, input int unsigned len, input int unsigned npkt);
    m_en[p] = 1'b1; m_len[p] = len; m_npkt[p] = npkt;
  endtask

  task automatic reset_all(input string tag);
    rst_n = 1'b0;
    clear_model();
    drive();
    repeat (2) begin @(posedge clk); #1; cyc++; end
    chk({tag, " rst rr tvalid"}, 32'(ov_rr), 0);
    chk({tag, " rst rr tdata"}, od_rr, 0);
    chk({tag, " rst rr tlast/tuser/tid"}, {ol_rr, ou_rr, oid_rr}, 0);
    chk({tag, " rst rr tready"}, 32'(rdy_rr), 0);
    chk({tag, " rst pri tvalid/tready"}, {ov_pri, rdy_pri}, 0);
    rst_n = 1'b1;
  endtask

  task automatic run_beats(input string tag, input int n, input int budget);
    int k = 0;
    while (cap.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk({tag, " beat count reached"}, 32'(cap.size() >= n), 1);
  endtask

  task automatic exp_beat(input string tag, input int idx, input int unsigned p,
                          input int unsigned pk, input int unsigned b, input logic last);
    if (idx >= cap.size()) begin
      checks++;
      errors++;
      $display("FAIL %s beat %0d missing got=%0d beats exp>%0d", tag, idx, cap.size(), idx);
    end else begin
      chk($sformatf("%s beat%0d data", tag, idx), cap[idx].data, bdata(p, pk, b));
      chk($sformatf("%s beat%0d tid", tag, idx), 32'(cap[idx].tid), p);
      chk($sformatf("%s beat%0d last/user", tag, idx), {cap[idx].last, cap[idx].user}, {last, buser(p, b)});
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int unsigned rr_ports[3];
    int unsigned bad;
    int k;

    rr_ports[0] = 0; rr_ports[1] = 1; rr_ports[2] = 3;
    use_pri = 1'b0;
    in_valid = '0; in_data = '0; in_last = '0; in_user = '0; out_ready = 1'b1;

    // {valid, data, last} on port 2 per cycle; {out valid, data, last, tid, tready} expected
    tv[0] = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h00, 1'b0, 2'd0, 4'b0000};
    tv[1] = '{1'b1, 32'h10, 1'b0, 1'b0, 32'h00, 1'b0, 2'd0, 4'b0100};
    tv[2] = '{1'b1, 32'h11, 1'b0, 1'b1, 32'h10, 1'b0, 2'd2, 4'b0100};
    tv[3] = '{1'b1, 32'h12, 1'b0, 1'b1, 32'h11, 1'b0, 2'd2, 4'b0100};
    tv[4] = '{1'b1, 32'h13, 1'b1, 1'b1, 32'h12, 1'b0, 2'd2, 4'b0100};
    tv[5] = '{1'b0, 32'h00, 1'b0, 1'b1, 32'h13, 1'b1, 2'd2, 4'b0000};
    tv[6] = '{1'b0, 32'h00, 1'b0, 1'b0, 32'h00, 1'b0, 2'd0, 4'b0000};

    // single port, table driven
    reset_all("t1");
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("t1 row%0d tvalid", i), 32'(ov_rr), 32'(tv[i].ev));
      if (tv[i].ev) begin
        chk($sformatf("t1 row%0d tdata", i), od_rr, tv[i].ed);
        chk($sformatf("t1 row%0d tlast/tid", i), {ol_rr, oid_rr}, {tv[i].el, tv[i].eid});
      end
      chk($sformatf("t1 row%0d tready", i), 32'(rdy_rr), 32'(tv[i].erdy));
      in_valid = '0; in_data = '0; in_last = '0; in_user = '0; out_ready = 1'b1;
      in_valid[2] = tv[i].v;
      in_data[2*DW +: DW] = tv[i].d;
      in_last[2] = tv[i].l;
      @(posedge clk); #1; cyc++;
    end

    // round robin over ports 0,1,3, back to back
    reset_all("t2");
    src(0, 2, 2); src(1, 2, 2); src(3, 2, 2);
    drive();
    c0 = cyc;
    run_beats("t2", 12, 40);
    for (int i = 0; i < 12; i++)
      exp_beat("t2", i, rr_ports[(i / 2) % 3], i / 6, i % 2, logic'(i % 2));
    if (cap.size() >= 12) begin
      chk("t2 first beat latency", 32'(cap[0].cyc - c0), 2);
      for (int i = 1; i < 12; i++)
        chk($sformatf("t2 no bubble beat%0d", i), 32'(cap[i].cyc - cap[0].cyc), 32'(i));
    end

    // fixed priority: 0 and 3 start together
    reset_all("t3a");
    use_pri = 1'b1;
    src(0, 2, 1); src(3, 2, 1);
    drive();
    run_beats("t3a", 4, 20);
    exp_beat("t3a", 0, 0, 0, 0, 1'b0);
    exp_beat("t3a", 1, 0, 0, 1, 1'b1);
    exp_beat("t3a", 2, 3, 0, 0, 1'b0);
    exp_beat("t3a", 3, 3, 0, 1, 1'b1);

    // port 2 first, then 1 and 3 wait: priority picks 1, round robin picks 3
    for (int pass = 0; pass < 2; pass++) begin
      reset_all(pass == 0 ? "t3b" : "t3c");
      use_pri = (pass == 0);
      src(2, 2, 1);
      drive();
      tick();
      src(1, 2, 1); src(3, 2, 1);
      drive();
      run_beats(pass == 0 ? "t3b" : "t3c", 6, 20);
      exp_beat(pass == 0 ? "t3b" : "t3c", 0, 2, 0, 0, 1'b0);
      exp_beat(pass == 0 ? "t3b" : "t3c", 2, pass == 0 ? 1 : 3, 0, 0, 1'b0);
      exp_beat(pass == 0 ? "t3b" : "t3c", 5, pass == 0 ? 3 : 1, 0, 1, 1'b1);
    end
    use_pri = 1'b0;

    // output backpressure 1,0,0,1 over an 8-beat packet
    reset_all("t4");
    src(0, 8, 1);
    bp_en = 1'b1;
    drive();
    run_beats("t4", 8, 60);
    repeat (6) tick();
    chk("t4 no duplicate beats", 32'(cap.size()), 8);
    for (int i = 0; i < 8; i++)
      exp_beat("t4", i, 0, 0, i, logic'(i == 7));

    // granted port stalls mid-packet; port 0 must not be readied
    reset_all("t5");
    src(1, 6, 1);
    m_stall_at[1] = 3; m_stall_left[1] = 3;
    drive();
    tick();
    src(0, 2, 1);
    drive();
    bad = 0; k = 0;
    while (m_pkt[1] < 1 && k < 40) begin
      if (rdy_rr[0]) bad++;
      tick();
      k++;
    end
    chk("t5 port1 packet completed", m_pkt[1], 1);
    chk("t5 port0 tready cycles during port1 pkt", bad, 0);
    run_beats("t5", 8, 30);
    for (int i = 0; i < 6; i++)
      exp_beat("t5", i, 1, 0, i, logic'(i == 5));
    exp_beat("t5", 6, 0, 0, 0, 1'b0);
    exp_beat("t5", 7, 0, 0, 1, 1'b1);

    // reset after beat 3 of 6, then a fresh packet from port 3
    reset_all("t6");
    src(0, 6, 1);
    drive();
    k = 0;
    while (m_beat[0] < 3 && k < 20) begin
      tick();
      k++;
    end
    chk("t6 three beats accepted", m_beat[0], 3);
    rst_n = 1'b0;
    clear_model();
    drive();
    @(posedge clk); #1; cyc++;
    chk("t6 post-reset tvalid", 32'(ov_rr), 0);
    chk("t6 post-reset tdata", od_rr, 0);
    chk("t6 post-reset tlast/tuser/tid", {ol_rr, ou_rr, oid_rr}, 0);
    chk("t6 post-reset tready", 32'(rdy_rr), 0);
    rst_n = 1'b1;
    src(3, 2, 1);
    drive();
    c0 = cyc;
    run_beats("t6", 2, 20);
    exp_beat("t6", 0, 3, 0, 0, 1'b0);
    exp_beat("t6", 1, 3, 0, 1, 1'b1);
    if (cap.size() >= 1) chk("t6 latency after reset", 32'(cap[0].cyc - c0), 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
